// File: rtl/cnt20_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnt20_sequencer
// Brief    : Step controller for a mod-MODULUS up/down counter: manual, auto
//            and ping-pong stepping with a shadow position.
// Revision : 1.0 - initial release
// ============================================================================
module cnt20_sequencer #(
  parameter int MODULUS  = 20,
  parameter int TICK_DIV = 4
) (
  input  logic       clock,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  output logic       step,
  output logic       dir,
  output logic [4:0] pos,
  output logic [1:0] state
);

  localparam int              c_TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [4:0]      c_POS_MAX  = 5'(MODULUS - 1);
  localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TURN = 2'd2
  } state_t;

  logic [4:1]      r_sync_a;
  logic [4:1]      r_sync;
  logic            r_s1_d;
  logic            r_s4_d;

  state_t          r_state, w_state;
  logic [c_TW-1:0] r_tick,  w_tick;
  logic            r_step,  w_step;
  logic            r_dir,   w_dir;
  logic [4:0]      r_pos,   w_pos;
  logic            r_pp,    w_pp;

  logic            w_req;
  logic            w_pp_eff;
  logic            w_d;
  logic            w_at_end;
  logic            w_due;

  always_ff @(posedge clock or negedge SW0) begin
    if (!SW0) begin
      r_sync_a <= '0;
      r_sync   <= '0;
      r_s1_d   <= 1'b0;
      r_s4_d   <= 1'b0;
    end else begin
      r_sync_a <= {SW4, SW3, SW2, SW1};
      r_sync   <= r_sync_a;
      r_s1_d   <= r_sync[1];
      r_s4_d   <= r_sync[4];
    end
  end

  assign w_req    = r_sync[1] & ~r_s1_d;
  // Ping-pong direction is captured from SW2 on the cycle the mode turns on.
  assign w_pp_eff = (r_sync[4] & ~r_s4_d) ? r_sync[2] : r_pp;
  assign w_d      = r_sync[4] ? w_pp_eff : r_sync[2];
  assign w_at_end = r_sync[4] & (w_d ? (r_pos == 5'd0) : (r_pos == c_POS_MAX));

  always_ff @(posedge clock or negedge SW0) begin
    if (!SW0) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_pos   <= '0;
      r_pp    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_step  <= w_step;
      r_dir   <= w_dir;
      r_pos   <= w_pos;
      r_pp    <= w_pp;
    end
  end

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_step  = 1'b0;
    w_dir   = r_dir;
    w_pos   = r_pos;
    w_pp    = w_pp_eff;
    w_due   = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_sync[3]) begin
          w_state = RUN;
          w_tick  = '0;
        end else begin
          w_due = w_req;
        end
      end
      RUN: begin
        // Leaving auto mode takes priority over a tick wrap on the same edge.
        if (!r_sync[3]) begin
          w_state = IDLE;
          w_tick  = '0;
        end else if (r_tick == c_TICK_MAX) begin
          w_tick = '0;
          w_due  = 1'b1;
        end else begin
          w_tick = r_tick + c_TW'(1);
        end
      end
      TURN: begin
        w_state = r_sync[3] ? RUN : IDLE;
        w_tick  = '0;
      end
      default: begin
        w_state = IDLE;
        w_tick  = '0;
      end
    endcase

    if (w_due) begin
      if (w_at_end) begin
        w_state = TURN;
        w_dir   = ~w_d;
        w_pp    = ~w_d;
      end else begin
        w_step = 1'b1;
        w_dir  = w_d;
        if (w_d) w_pos = (r_pos == 5'd0) ? c_POS_MAX : r_pos - 5'd1;
        else     w_pos = (r_pos == c_POS_MAX) ? 5'd0 : r_pos + 5'd1;
      end
    end
  end

  assign step  = r_step;
  assign dir   = r_dir;
  assign pos   = r_pos;
  assign state = r_state;

endmodule
`default_nettype wire
